// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: word-aligned memory access, load extension,
// sub-word stores via a two-cycle read-modify-write, fault flagging.
module mem_access_unit #(
    parameter int unsigned RAM_SIZE = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        exc,
    output logic [31:0] exc_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {
        IDLE,
        MERGE
    } state_t;

    state_t      state;
    logic [31:0] lat_rdata;
    logic [29:0] lat_waddr;
    logic [15:0] lat_wdata;
    logic        lat_half;
    logic [1:0]  lat_off;

    logic is_word;
    logic fault;
    logic accept;

    function automatic logic [31:0] extend(input logic [31:0] word, input logic [1:0] size,
                                           input logic [1:0] off, input logic sgn);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = word >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   extend = {{24{sgn & b[7]}}, b};
            2'b01:   extend = {{16{sgn & h[15]}}, h};
            default: extend = word;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [15:0] wd,
                                          input logic half, input logic [1:0] off);
        logic [4:0]  sh;
        logic [31:0] mask;
        logic [31:0] data;
        if (half) begin
            sh   = {off[1], 4'b0000};
            mask = 32'h0000_FFFF << sh;
            data = {16'h0000, wd} << sh;
        end else begin
            sh   = {off, 3'b000};
            mask = 32'h0000_00FF << sh;
            data = {24'h00_0000, wd[7:0]} << sh;
        end
        merge = (word & ~mask) | (data & mask);
    endfunction

    // Reserved size 11 behaves as a word access.
    assign is_word = req_size[1];
    assign fault   = (req_size == 2'b01 && req_addr[0])
                   || (is_word && req_addr[1:0] != 2'b00)
                   || (req_addr >= 32'(RAM_SIZE));
    assign accept  = !reset && state == IDLE && req_valid && !fault;

    // Memory side is decoded combinationally; reset suppresses every enable,
    // which is what drops a pending merge write.
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        stall     = 1'b0;
        mem_addr  = {req_addr[31:2], 2'b00};
        mem_wdata = req_wdata;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!req_wr) begin
                            mem_rd = 1'b1;
                        end else if (is_word) begin
                            mem_wr = 1'b1;
                        end else begin
                            mem_rd = 1'b1;
                            stall  = 1'b1;
                        end
                    end
                end
                MERGE: begin
                    mem_wr    = 1'b1;
                    mem_addr  = {lat_waddr, 2'b00};
                    mem_wdata = merge(lat_rdata, lat_wdata, lat_half, lat_off);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            load_data  <= '0;
            load_valid <= 1'b0;
            exc        <= 1'b0;
            exc_addr   <= '0;
            lat_rdata  <= '0;
            lat_waddr  <= '0;
            lat_wdata  <= '0;
            lat_half   <= 1'b0;
            lat_off    <= '0;
        end else begin
            load_valid <= 1'b0;
            exc        <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (fault) begin
                            exc      <= 1'b1;
                            exc_addr <= req_addr;
                        end else if (!req_wr) begin
                            load_valid <= 1'b1;
                            load_data  <= extend(mem_rdata, req_size, req_addr[1:0], req_signed);
                        end else if (!is_word) begin
                            lat_rdata <= mem_rdata;
                            lat_waddr <= req_addr[31:2];
                            lat_wdata <= req_wdata[15:0];
                            lat_half  <= req_size[0];
                            lat_off   <= req_addr[1:0];
                            state     <= MERGE;
                        end
                    end
                end
                MERGE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word memory model and a
// scoreboard monitor for the registered load/exception outputs.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        exc;
    logic [31:0] exc_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [0:31];
    logic [31:0] load_q [$];
    logic [31:0] exc_q [$];
    int checks = 0;
    int errors = 0;

    mem_access_unit #(.RAM_SIZE(128)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_wr(req_wr),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .load_data(load_data),
        .load_valid(load_valid), .exc(exc), .exc_addr(exc_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr[6:2]];
    always @(posedge clk) if (mem_wr) ram[mem_addr[6:2]] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: each registered pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (load_valid && exc) chk("lv_exc_exclusive", 32'd1, 32'd0);
            if (load_valid) begin
                if (load_q.size() == 0) chk("unexpected_load_valid", 32'd1, 32'd0);
                else chk("load_data", load_data, load_q.pop_front());
            end
            if (exc) begin
                if (exc_q.size() == 0) chk("unexpected_exc", 32'd1, 32'd0);
                else chk("exc_addr", exc_addr, exc_q.pop_front());
            end
        end
    end

    task automatic apply(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_wr     = wr;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    task automatic load(input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                        input logic [31:0] exp);
        apply(1'b0, size, sgn, addr, 32'h0);
        load_q.push_back(exp);
        @(negedge clk);
        chk("ld_mem_rd", {31'b0, mem_rd}, 32'd1);
        chk("ld_mem_wr", {31'b0, mem_wr}, 32'd0);
        chk("ld_stall", {31'b0, stall}, 32'd0);
        chk("ld_mem_addr", mem_addr, {addr[31:2], 2'b00});
    endtask

    task automatic wstore(input logic [31:0] addr, input logic [31:0] wdata);
        apply(1'b1, 2'b10, 1'b0, addr, wdata);
        @(negedge clk);
        chk("sw_mem_wr", {31'b0, mem_wr}, 32'd1);
        chk("sw_mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("sw_stall", {31'b0, stall}, 32'd0);
        chk("sw_mem_addr", mem_addr, addr);
        chk("sw_mem_wdata", mem_wdata, wdata);
    endtask

    task automatic sstore(input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] merged);
        apply(1'b1, size, 1'b1, addr, wdata);
        @(negedge clk);
        chk("rmw1_mem_rd", {31'b0, mem_rd}, 32'd1);
        chk("rmw1_mem_wr", {31'b0, mem_wr}, 32'd0);
        chk("rmw1_stall", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rmw2_mem_wr", {31'b0, mem_wr}, 32'd1);
        chk("rmw2_mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("rmw2_stall", {31'b0, stall}, 32'd0);
        chk("rmw2_mem_addr", mem_addr, {addr[31:2], 2'b00});
        chk("rmw2_mem_wdata", mem_wdata, merged);
    endtask

    task automatic fault(input logic wr, input logic [1:0] size, input logic [31:0] addr);
        apply(wr, size, 1'b0, addr, 32'h5A5A_5A5A);
        exc_q.push_back(addr);
        @(negedge clk);
        chk("flt_mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("flt_mem_wr", {31'b0, mem_wr}, 32'd0);
        chk("flt_stall", {31'b0, stall}, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_load_valid", {31'b0, load_valid}, 32'd0);
        chk("rst_exc", {31'b0, exc}, 32'd0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_exc_addr", exc_addr, 32'h0);
        chk("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Word store / load
        wstore(32'h10, 32'hDEADBEEF);
        load(2'b10, 1'b1, 32'h10, 32'hDEADBEEF);
        wstore(32'h20, 32'h80FF7F01);
        wstore(32'h30, 32'h11223344);
        wstore(32'h40, 32'hCAFEF00D);

        // Sub-word loads
        load(2'b00, 1'b1, 32'h22, 32'hFFFFFFFF);
        load(2'b00, 1'b0, 32'h23, 32'h00000080);
        load(2'b00, 1'b1, 32'h21, 32'h0000007F);
        load(2'b01, 1'b1, 32'h22, 32'hFFFF80FF);
        load(2'b01, 1'b0, 32'h20, 32'h00007F01);
        load(2'b00, 1'b0, 32'h20, 32'h00000001);
        load(2'b11, 1'b1, 32'h20, 32'h80FF7F01);
        idle(1);

        // Byte store read-modify-write
        sstore(2'b00, 32'h31, 32'h000000AB, 32'h1122AB44);
        load(2'b10, 1'b0, 32'h30, 32'h1122AB44);
        idle(1);

        // Faults
        fault(1'b0, 2'b10, 32'h06);
        fault(1'b1, 2'b01, 32'h0B);
        fault(1'b0, 2'b10, 32'h80);
        idle(1);
        load(2'b10, 1'b0, 32'h7C, ram[31]);
        idle(2);

        // Reset during MERGE drops the store
        apply(1'b1, 2'b01, 1'b0, 32'h40, 32'h00001234);
        @(negedge clk);
        chk("rm_stall", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rm_mem_wr", {31'b0, mem_wr}, 32'd0);
        chk("rm_mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("rm_stall2", {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("rm_load_data", load_data, 32'h0);
        chk("rm_exc_addr", exc_addr, 32'h0);
        chk("rm_load_valid", {31'b0, load_valid}, 32'd0);
        chk("rm_exc", {31'b0, exc}, 32'd0);
        chk("rm_ram", ram[16], 32'hCAFEF00D);
        load(2'b10, 1'b0, 32'h40, 32'hCAFEF00D);

        // Back-to-back load, halfword store, load
        load(2'b10, 1'b0, 32'h30, 32'h1122AB44);
        sstore(2'b01, 32'h32, 32'hFFFF5566, 32'h5566AB44);
        load(2'b10, 1'b0, 32'h30, 32'h5566AB44);
        load(2'b01, 1'b1, 32'h32, 32'h00005566);
        idle(4);

        chk("load_q_drained", load_q.size(), 32'd0);
        chk("exc_q_drained", exc_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store unit sitting directly upstream of the word-addressed data memory.
- Converts pipeline byte/halfword/word load and store requests into word-aligned memory reads and writes.
- Performs sign/zero extension on loads.
- Implements sub-word stores as a 2-cycle read-modify-write, stalling the pipeline for one cycle.
- Flags misaligned and out-of-range accesses instead of issuing them.

Parameters:
RAM_SIZE, 128, byte-address limit of the data memory; addresses >= RAM_SIZE are out of range.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  MEM-stage request present this cycle
req_wr  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  input  32  byte address
req_wdata  input  32  store data; sub-word data in the low bits
stall  output  1  combinational; holds the MEM stage and all upstream stages
load_data  output  32  registered, extended load result
load_valid  output  1  registered one-cycle pulse qualifying load_data
exc  output  1  registered one-cycle pulse: misaligned or out-of-range request
exc_addr  output  32  registered; req_addr of the faulting request
mem_rd  output  1  memory read enable
mem_wr  output  1  memory write enable
mem_addr  output  32  word-aligned address, bits [1:0] always 00
mem_wdata  output  32  memory write data
mem_rdata  input  32  memory read data, combinational from mem_addr

Behaviour:
Reset:
- Synchronous on the clk rising edge with reset=1. State goes to IDLE.
- load_data=0, load_valid=0, exc=0, exc_addr=0, internal latches=0.
- The memory outputs decode to mem_rd=0, mem_wr=0, stall=0.

Fault check (IDLE only):
- Fault when req_size=01 with addr[0]=1, or word size with addr[1:0]!=00, or req_addr >= RAM_SIZE.
- On a faulting request: no mem_rd/mem_wr and no stall.
- Next cycle: exc=1, exc_addr=req_addr, load_valid=0.

State IDLE:
- No req_valid: all memory enables are 0.
- Load:
  - Same cycle: mem_rd=1, mem_addr={req_addr[31:2],2'b00}.
  - Byte lane = addr[1:0], little-endian: lane 0 = bits[7:0]; halfword uses bits[15:0] or [31:16] per addr[1].
  - The lane is extended per req_signed and registered: load_valid=1 with load_data on the next cycle.
  - Latency 1, stall=0.
- Word store: same cycle mem_wr=1, mem_wdata=req_wdata, stall=0, stays in IDLE.
- Sub-word store:
  - Same cycle: mem_rd=1 and stall=1.
  - Latch mem_rdata, the aligned address, req_wdata, req_size and addr[1:0]; go to MERGE.

State MERGE:
- mem_wr=1 and mem_addr=latched address.
- mem_wdata = latched word with the target byte/halfword lanes replaced by latched wdata[7:0]/[15:0].
- stall=0, so the pipeline advances at the end of this cycle. Return to IDLE.
- Request inputs are ignored in MERGE (they still carry the same store).
- mem_rd=0.

Timing and exclusivity:
- load_valid and exc are never high together.
- Each pulse lasts exactly one cycle unless a new qualifying request arrives.
- Back-to-back loads produce one load_valid per cycle.

Reset in MERGE:
- Returns to IDLE with no write issued; the pending store is dropped.

Misc:
- Stores never raise load_valid.
- req_signed is ignored for word loads and for all stores.

Test Plan:
1. Reset then word store/load:
   - Store addr=0x10, wdata=0xDEADBEEF: mem_wr=1 same cycle, mem_addr=0x10, stall=0.
   - Load word 0x10: next cycle load_valid=1, load_data=0xDEADBEEF.
2. Byte loads with memory word 0x80FF7F01 at 0x20:
   - addr 0x22 signed -> 0xFFFFFFFF.
   - addr 0x23 unsigned -> 0x00000080.
   - addr 0x21 signed -> 0x0000007F.
   - Halfword 0x22 signed -> 0xFFFF80FF.
3. Byte store RMW with word 0x11223344 at 0x30, sb addr=0x31, wdata=0xAB:
   - Cycle 1: mem_rd=1, stall=1.
   - Cycle 2: mem_wr=1, mem_wdata=0x1122AB44, stall=0.
   - A subsequent word load returns 0x1122AB44.
4. Misalignment/range:
   - Word load at 0x06: exc=1, exc_addr=0x06, no mem_rd.
   - Halfword store at 0x0B: exc=1, no mem_wr.
   - Word load at 0x80 with RAM_SIZE=128: exc=1.
5. Reset during MERGE:
   - Start sh addr=0x40; assert reset in the MERGE cycle.
   - Required: mem_wr=0 that cycle, state IDLE, all outputs 0.
   - Memory word at 0x40 unchanged.
6. Back-to-back load, halfword store, load on consecutive requests:
   - Exactly one stall cycle.
   - load_valid pulses align 1 cycle after each load accept.
   - The second load reads the merged value.
